// File: rtl/shift_add_mult_param_if.sv
// Start/busy/done handshake and operand/result bus for the shift-and-add multiplier.
// The master drives the request, the slave returns the product and status.
interface shift_add_mult_param_if #(
    parameter int unsigned D_WIDTH = 8
);
    logic                   i_start;
    logic                   i_signed;
    logic [D_WIDTH-1:0]     i_multiplicand;
    logic [D_WIDTH-1:0]     i_multiplier;
    logic [2*D_WIDTH-1:0]   o_product;
    logic                   o_busy;
    logic                   o_done;
    logic [1:0]             o_state;

    modport master (
        output i_start,
        output i_signed,
        output i_multiplicand,
        output i_multiplier,
        input  o_product,
        input  o_busy,
        input  o_done,
        input  o_state
    );

    modport slave (
        input  i_start,
        input  i_signed,
        input  i_multiplicand,
        input  i_multiplier,
        output o_product,
        output o_busy,
        output o_done,
        output o_state
    );
endinterface

// File: rtl/shift_add_mult_param.sv
// Width-generic sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed mode multiplies magnitudes and negates the result when operand signs differ.
module shift_add_mult_param #(
    parameter int unsigned D_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    shift_add_mult_param_if.slave   io_mul
);

    localparam int unsigned CNT_WIDTH = $clog2(D_WIDTH + 1);
    localparam int unsigned P_WIDTH   = 2 * D_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ITER = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(D_WIDTH - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [P_WIDTH:0]       r_acc;
    logic [D_WIDTH-1:0]     r_mcand;
    logic [D_WIDTH-1:0]     r_mplier;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_neg;
    logic                   r_signed;
    logic [P_WIDTH-1:0]     r_product;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [D_WIDTH-1:0]     w_a_mag;
    logic [D_WIDTH-1:0]     w_b_mag;
    logic [D_WIDTH-1:0]     w_addend;
    logic [D_WIDTH:0]       w_sum;
    logic [P_WIDTH:0]       w_acc_next;
    logic [P_WIDTH-1:0]     w_result;

    // Most-negative operand negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        w_a_neg = io_mul.i_signed & io_mul.i_multiplicand[D_WIDTH-1];
        w_b_neg = io_mul.i_signed & io_mul.i_multiplier[D_WIDTH-1];
        w_a_mag = w_a_neg ? (~io_mul.i_multiplicand + 1'b1) : io_mul.i_multiplicand;
        w_b_mag = w_b_neg ? (~io_mul.i_multiplier + 1'b1) : io_mul.i_multiplier;
    end

    // Add into the upper half with carry, then shift the whole accumulator right by one.
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_sum      = r_acc[P_WIDTH:D_WIDTH] + {1'b0, w_addend};
        w_acc_next = {1'b0, w_sum, r_acc[D_WIDTH-1:1]};
        w_result   = r_neg ? (~r_acc[P_WIDTH-1:0] + 1'b1) : r_acc[P_WIDTH-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (io_mul.i_start) w_state_next = ST_ITER;
            ST_ITER: if (r_cnt == LAST_CNT) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (io_mul.i_start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_signed <= io_mul.i_signed;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_ITER: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_product <= w_result;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // r_signed is retained as the captured mode for debug visibility alongside o_state.
    logic w_mode_unused;
    assign w_mode_unused = r_signed;

    assign io_mul.o_product = r_product;
    assign io_mul.o_busy    = r_busy;
    assign io_mul.o_done    = r_done;
    assign io_mul.o_state   = r_state;

endmodule

// File: tb/tb_shift_add_mult_param.sv
// Bench for shift_add_mult_param: directed 8-bit vector table, handshake/reset corners,
// and random 16-bit operands against an arithmetic reference.
module tb_shift_add_mult_param;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    shift_add_mult_param_if #(.D_WIDTH(8))  if8 ();
    shift_add_mult_param_if #(.D_WIDTH(16)) if16 ();

    shift_add_mult_param #(.D_WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mul  (if8)
    );

    shift_add_mult_param #(.D_WIDTH(16)) dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_mul  (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                        input logic [15:0] exp, input logic [15:0] prev, input string nm);
        int edges = 0;
        int busy  = 0;
        bit seen  = 0;
        @(negedge clk);
        if8.i_multiplicand = a;
        if8.i_multiplier   = b;
        if8.i_signed       = sg;
        if8.i_start        = 1'b1;
        @(posedge clk);
        #1;
        if8.i_start        = 1'b0;
        if8.i_multiplicand = 8'($urandom);
        if8.i_multiplier   = 8'($urandom);
        if8.i_signed       = 1'($urandom);
        if (if8.o_busy) busy++;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 4) chk({nm, " hold"}, 64'(if8.o_product), 64'(prev));
            if (if8.o_busy) busy++;
            if (if8.o_done) seen = 1;
        end
        chk({nm, " product"}, 64'(if8.o_product), 64'(exp));
        chk({nm, " latency"}, 64'(edges), 64'd9);
        chk({nm, " busy"}, 64'(busy), 64'd9);
        @(posedge clk);
        #1;
        chk({nm, " done-pulse"}, 64'({if8.o_done, if8.o_state}), 64'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                         input logic [31:0] exp, input string nm);
        int edges = 0;
        bit seen  = 0;
        @(negedge clk);
        if16.i_multiplicand = a;
        if16.i_multiplier   = b;
        if16.i_signed       = sg;
        if16.i_start        = 1'b1;
        @(posedge clk);
        #1;
        if16.i_start        = 1'b0;
        if16.i_multiplicand = 16'($urandom);
        if16.i_multiplier   = 16'($urandom);
        while (!seen && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (if16.o_done) seen = 1;
        end
        chk({nm, " product"}, 64'(if16.o_product), 64'(exp));
        chk({nm, " latency"}, 64'(edges), 64'd17);
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer multiply of the operands read as signed or unsigned.
    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic sg);
        longint x;
        longint y;
        longint p;
        x = sg ? longint'($signed(a)) : longint'(a);
        y = sg ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[31:0];
    endfunction

    initial begin
        logic [15:0] prev;
        int          dones;
        int          hs_edges;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        vecs[0] = '{8'h03, 8'h0E, 1'b0, 16'h002A};
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[2] = '{8'h00, 8'hAB, 1'b0, 16'h0000};
        vecs[3] = '{8'hFD, 8'h0E, 1'b1, 16'hFFD6};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[7] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};

        rst_n = 1'b0;
        if8.i_start = 1'b0;  if8.i_signed = 1'b0;
        if8.i_multiplicand = '0;  if8.i_multiplier = '0;
        if16.i_start = 1'b0; if16.i_signed = 1'b0;
        if16.i_multiplicand = '0; if16.i_multiplier = '0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("reset-idle8", 64'({if8.o_product, if8.o_busy, if8.o_done, if8.o_state}), 64'd0);
            chk("reset-idle16", 64'({if16.o_product, if16.o_busy, if16.o_done, if16.o_state}),
                64'd0);
        end

        prev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].exp, prev, $sformatf("vec%0d", i));
            prev = vecs[i].exp;
        end

        // Re-assert start with new operands mid-operation; only the first request may complete.
        @(negedge clk);
        if8.i_multiplicand = 8'h03;
        if8.i_multiplier   = 8'h0E;
        if8.i_signed       = 1'b0;
        if8.i_start        = 1'b1;
        @(posedge clk);
        #1;
        if8.i_start = 1'b0;
        dones    = 0;
        hs_edges = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                if8.i_start        = 1'b1;
                if8.i_multiplicand = 8'hFF;
                if8.i_multiplier   = 8'hFF;
                if8.i_signed       = 1'b1;
            end
            if (if8.o_done) begin
                dones++;
                if (hs_edges == 0) hs_edges = e;
                if8.i_start = 1'b0;
            end
        end
        if8.i_start = 1'b0;
        chk("busy-start product", 64'(if8.o_product), 64'h002A);
        chk("busy-start done count", 64'(dones), 64'd1);
        chk("busy-start latency", 64'(hs_edges), 64'd9);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        if8.i_multiplicand = 8'hFF;
        if8.i_multiplier   = 8'hFF;
        if8.i_signed       = 1'b0;
        if8.i_start        = 1'b1;
        @(posedge clk);
        #1;
        if8.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset outputs", 64'({if8.o_product, if8.o_busy, if8.o_done, if8.o_state}),
            64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (if8.o_done) dones++;
        end
        chk("mid-reset no done", 64'(dones), 64'd0);
        chk("mid-reset idle", 64'({if8.o_busy, if8.o_state}), 64'd0);

        run16(16'h8000, 16'h8000, 1'b1, model16(16'h8000, 16'h8000, 1'b1), "w16 minmin");
        run16(16'hFFFF, 16'hFFFF, 1'b0, model16(16'hFFFF, 16'hFFFF, 1'b0), "w16 maxmax");
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            run16(ra, rb, rs, model16(ra, rb, rs), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_param.md
Name: shift_add_mult_param

Overview:
Parametrised sequential shift-and-add multiplier. It is the width-generic successor to the fixed 8-bit datapath/controller multiplier pair. Both operands are captured in parallel on a start handshake. One multiplier bit is retired per clock, and the block supports unsigned and two's-complement signed products via a per-operation mode bit. It sits beside the existing arithmetic datapath blocks as a self-contained unit with start/busy/done handshake and a state debug output.

Parameters:
D_WIDTH, 8, operand width in bits (legal range 2 to 32); product width is 2*D_WIDTH.
CNT_WIDTH, $clog2(D_WIDTH+1), iteration counter width (derived; do not override).

Ports:
i_clk  input  1  system clock, rising-edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  start request; sampled only in IDLE.
i_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with i_start.
i_multiplicand  input  D_WIDTH  operand A; sampled with i_start.
i_multiplier  input  D_WIDTH  operand B; sampled with i_start.
o_product  output  2*D_WIDTH  registered result; held until the next result is written.
o_busy  output  1  high from the cycle after start acceptance through the FIX cycle.
o_done  output  1  single-cycle pulse; result valid on o_product.
o_state  output  2  current FSM state encoding (debug).

Behaviour:
- Reset (async assert, sync release by design):
  - state = IDLE, o_product = 0, o_busy = 0, o_done = 0.
  - Accumulator, counter and internal operand registers all = 0.
- States and o_state encoding: IDLE = 2'b00, ITER = 2'b01, FIX = 2'b10, DONE = 2'b11.
- IDLE:
  - o_done = 0.
  - On an edge with i_start = 1, capture the operand magnitudes, neg_flag and mode, then go to ITER.
  - Magnitude rule: when i_signed = 1, each operand is replaced by its absolute value (D_WIDTH-bit unsigned).
  - The most-negative value maps to 2^(D_WIDTH-1), which fits in D_WIDTH bits.
  - neg_flag = sign(A) XOR sign(B) when i_signed = 1; neg_flag = 0 otherwise.
  - Accumulator is cleared and counter is set to 0 on the same edge.
- ITER: one edge per multiplier bit, D_WIDTH edges total.
  - If the multiplier LSB = 1, add the multiplicand into the upper half of the (2*D_WIDTH+1)-bit accumulator. The carry is kept.
  - The accumulator/multiplier pair is shifted right by 1.
  - Counter increments; when counter = D_WIDTH-1, go to FIX.
- FIX (one edge):
  - o_product = neg_flag ? two's-complement negation of the accumulator's low 2*D_WIDTH bits : those bits.
  - o_done asserts on this edge; go to DONE.
- DONE: o_done = 1 for exactly this cycle; o_busy = 0. Next edge goes to IDLE unconditionally; i_start in DONE is ignored.
- Latency: the start edge is edge 0, and o_product/o_done update on edge D_WIDTH+1. Back-to-back operations are therefore D_WIDTH+3 cycles apart.
- i_start while busy (ITER/FIX/DONE) is ignored. It is not queued, and operands are not re-sampled.
- Operand inputs may change freely after the start edge without affecting the result.
- o_product keeps its previous value throughout a new operation until FIX.
- Reset asserted mid-operation aborts immediately to reset values; no o_done is produced.
- Zero operands still take the full D_WIDTH iterations (no early termination).

Test Plan:
- Reset/idle: hold i_rst_n = 0, then release with i_start = 0 for 20 cycles -> o_product = 0, o_busy = 0, o_done = 0, o_state = 00 throughout.
- Unsigned, D_WIDTH = 8: A = 8'h03, B = 8'h0E, i_signed = 0, start pulse.
  - o_done pulses exactly 9 edges after the start edge.
  - o_product = 16'h002A.
  - o_busy is high for 9 cycles.
- Unsigned max, D_WIDTH = 8: A = 8'hFF, B = 8'hFF -> o_product = 16'hFE01. Then A = 8'h00, B = 8'hAB -> o_product = 16'h0000 with identical latency.
- Signed, D_WIDTH = 8, i_signed = 1:
  - A = 8'hFD (-3), B = 8'h0E -> 16'hFFD6 (-42).
  - A = 8'h80, B = 8'h80 -> 16'h4000.
  - A = 8'h80, B = 8'h01 -> 16'hFF80.
- Handshake robustness:
  - Assert i_start again and change operands during ITER -> result stays that of the first operands, and only one o_done occurs.
  - Pulse i_rst_n low during ITER -> outputs go to 0 asynchronously, and no o_done follows.
- Parametric: rebuild with D_WIDTH = 16 and run 200 random signed/unsigned operand pairs against a behavioural model.
  - Every product must match.
  - o_done must arrive 17 edges after each accepted start.
